// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : exe_stage
//  Purpose  : Execute stage of the 5-stage in-order pipeline. Latches the
//             ID->EX bus, computes the ALU / multiply result, runs div/mod on
//             an iterative 32-step restoring divider (stalling the stage while
//             it works), issues the data-SRAM request and exports the EX->MEM
//             and EX->ID (forwarding/hazard) buses.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset       clock, synchronous active-high reset
//    ms_allowin       MEM can accept an instruction this cycle
//    es_allowin       EX can accept an instruction this cycle
//    ds_to_es_valid   ID presents a valid instruction
//    ds_to_es_bus     {alu_op[11:0], md_op[2:0], mem_we, res_from_mem, gr_we,
//                      dest[4:0], src1, src2, rkd_value, pc}
//    es_to_ms_valid   EX presents a valid instruction to MEM
//    es_to_ms_bus     {res_from_mem, gr_we, dest[4:0], result, pc}
//    es_to_ds_bus     {fwd_valid, is_load, dest[4:0], result}
//    data_sram_*      word-wide data-SRAM request (en, we[3:0], addr, wdata)
// ============================================================================
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [150:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic [38:0]  es_to_ds_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  typedef enum logic [1:0] {
    S_DIV_IDLE = 2'd0,
    S_DIV_BUSY = 2'd1,
    S_DIV_DONE = 2'd2
  } div_state_t;

  // --------------------------------------------------------------------------
  // Pipeline register
  // --------------------------------------------------------------------------
  logic         r_es_valid;
  logic [150:0] r_ds_bus;
  logic         w_es_ready_go;

  // --------------------------------------------------------------------------
  // Bus field decode
  // --------------------------------------------------------------------------
  logic [11:0] w_alu_op;
  logic [2:0]  w_md_op;
  logic        w_mem_we;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_rkd_value;
  logic [31:0] w_pc;

  assign {w_alu_op, w_md_op, w_mem_we, w_res_from_mem, w_gr_we, w_dest,
          w_src1, w_src2, w_rkd_value, w_pc} = r_ds_bus;

  // --------------------------------------------------------------------------
  // ALU (one-hot select, OR of masked terms; all-zero op yields 0)
  // --------------------------------------------------------------------------
  logic [31:0] w_add;
  logic [31:0] w_sub;
  logic [31:0] w_slt;
  logic [31:0] w_sltu;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic [31:0] w_alu_result;

  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'd0, ($signed(w_src1) < $signed(w_src2))};
  assign w_sltu = {31'd0, (w_src1 < w_src2)};
  assign w_sll  = w_src1 << w_src2[4:0];
  assign w_srl  = w_src1 >> w_src2[4:0];
  assign w_sra  = $signed(w_src1) >>> w_src2[4:0];

  assign w_alu_result = ({32{w_alu_op[0]}}  & w_add)
                      | ({32{w_alu_op[1]}}  & w_sub)
                      | ({32{w_alu_op[2]}}  & w_slt)
                      | ({32{w_alu_op[3]}}  & w_sltu)
                      | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                      | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                      | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                      | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                      | ({32{w_alu_op[8]}}  & w_sll)
                      | ({32{w_alu_op[9]}}  & w_srl)
                      | ({32{w_alu_op[10]}} & w_sra)
                      | ({32{w_alu_op[11]}} & w_src2);

  // --------------------------------------------------------------------------
  // Single-cycle multiplier. Operands are extended to 64 bits (sign-extended
  // only for mulh.w); the low 64 bits of the product are then exact for both
  // signed and unsigned interpretations.
  // --------------------------------------------------------------------------
  logic        w_mul_signed;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;

  assign w_mul_signed = (w_md_op == 3'b010);
  assign w_mul_a      = {{32{w_mul_signed & w_src1[31]}}, w_src1};
  assign w_mul_b      = {{32{w_mul_signed & w_src2[31]}}, w_src2};
  assign w_prod       = w_mul_a * w_mul_b;

  // --------------------------------------------------------------------------
  // Iterative restoring divider
  //   r_div_q : dividend shifts out MSB-first while quotient bits shift in
  //   r_div_r : partial remainder (always < divisor, so 32 bits suffice)
  // --------------------------------------------------------------------------
  div_state_t  r_div_state;
  logic [4:0]  r_div_cnt;
  logic [31:0] r_div_q;
  logic [31:0] r_div_r;
  logic [31:0] r_div_d;

  logic        w_is_div;
  logic        w_div_signed;
  logic        w_s1_neg;
  logic        w_s2_neg;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_part;
  logic        w_ge;
  logic [31:0] w_rem_next;
  logic        w_div_by_zero;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;

  assign w_is_div     = w_md_op[2];
  assign w_div_signed = ~w_md_op[1];
  assign w_s1_neg     = w_div_signed & w_src1[31];
  assign w_s2_neg     = w_div_signed & w_src2[31];
  assign w_abs1       = w_s1_neg ? (32'd0 - w_src1) : w_src1;
  assign w_abs2       = w_s2_neg ? (32'd0 - w_src2) : w_src2;

  assign w_part     = {r_div_r, r_div_q[31]};
  assign w_ge       = (w_part >= {1'b0, r_div_d});
  // When w_ge holds the difference is below the divisor, so 32 bits are exact.
  assign w_rem_next = w_ge ? (w_part[31:0] - r_div_d) : w_part[31:0];

  // Divide-by-zero bypasses sign correction: q = all ones, r = raw dividend.
  assign w_div_by_zero = (w_src2 == 32'd0);
  assign w_div_q = w_div_by_zero        ? 32'hFFFF_FFFF :
                   (w_s1_neg ^ w_s2_neg) ? (32'd0 - r_div_q) : r_div_q;
  assign w_div_r = w_div_by_zero ? w_src1 :
                   w_s1_neg      ? (32'd0 - r_div_r) : r_div_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_state <= S_DIV_IDLE;
      r_div_cnt   <= 5'd0;
      r_div_q     <= 32'd0;
      r_div_r     <= 32'd0;
      r_div_d     <= 32'd0;
    end else begin
      case (r_div_state)
        S_DIV_IDLE: begin
          if (r_es_valid && w_is_div) begin
            r_div_state <= S_DIV_BUSY;
            r_div_q     <= w_abs1;
            r_div_d     <= w_abs2;
            r_div_r     <= 32'd0;
            r_div_cnt   <= 5'd0;
          end
        end
        S_DIV_BUSY: begin
          r_div_q <= {r_div_q[30:0], w_ge};
          r_div_r <= w_rem_next;
          if (r_div_cnt == 5'd31) begin
            r_div_state <= S_DIV_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + 5'd1;
          end
        end
        S_DIV_DONE: begin
          if (es_to_ms_valid && ms_allowin) begin
            r_div_state <= S_DIV_IDLE;
          end
        end
        default: r_div_state <= S_DIV_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result select
  // --------------------------------------------------------------------------
  logic [31:0] w_result;

  always_comb begin
    w_result = w_alu_result;
    case (w_md_op)
      3'b001:         w_result = w_prod[31:0];
      3'b010, 3'b011: w_result = w_prod[63:32];
      3'b100, 3'b110: w_result = w_div_q;
      3'b101, 3'b111: w_result = w_div_r;
      default:        w_result = w_alu_result;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and pipeline register
  // --------------------------------------------------------------------------
  assign w_es_ready_go  = ~(w_is_div && (r_div_state != S_DIV_DONE));
  assign es_allowin     = ~r_es_valid | (w_es_ready_go & ms_allowin);
  assign es_to_ms_valid = r_es_valid & w_es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_es_valid <= 1'b0;
      r_ds_bus   <= '0;
    end else begin
      if (es_allowin) begin
        r_es_valid <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allowin) begin
        r_ds_bus <= ds_to_es_bus;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data-SRAM request: only in the transfer cycle, so a stall never re-issues
  // --------------------------------------------------------------------------
  assign data_sram_en    = r_es_valid & w_es_ready_go & ms_allowin &
                           (w_res_from_mem | w_mem_we);
  assign data_sram_we    = {4{data_sram_en & w_mem_we}};
  assign data_sram_addr  = w_add;
  assign data_sram_wdata = w_rkd_value;

  // --------------------------------------------------------------------------
  // Output buses
  // --------------------------------------------------------------------------
  assign es_to_ms_bus = {w_res_from_mem, w_gr_we, w_dest, w_result, w_pc};
  assign es_to_ds_bus = {(r_es_valid & w_gr_we & (w_dest != 5'd0)),
                         w_res_from_mem, w_dest, w_result};

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_stage
//  Purpose  : Self-checking bench for exe_stage. A vector table drives the
//             ALU / multiply / divide paths; expected EX->MEM records go to a
//             scoreboard queue and are compared on every transfer. Hand
//             sequences cover loads, stalled stores, divider latency with a
//             back-to-back younger op, DONE hold, and reset mid-divide.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [150:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_bus    (es_to_ds_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  localparam logic [11:0] A_ADD  = 12'h001;
  localparam logic [11:0] A_SUB  = 12'h002;
  localparam logic [11:0] A_SLT  = 12'h004;
  localparam logic [11:0] A_SLTU = 12'h008;
  localparam logic [11:0] A_AND  = 12'h010;
  localparam logic [11:0] A_NOR  = 12'h020;
  localparam logic [11:0] A_OR   = 12'h040;
  localparam logic [11:0] A_XOR  = 12'h080;
  localparam logic [11:0] A_SLL  = 12'h100;
  localparam logic [11:0] A_SRL  = 12'h200;
  localparam logic [11:0] A_SRA  = 12'h400;
  localparam logic [11:0] A_LUI  = 12'h800;
  localparam int          NV     = 27;

  typedef struct {
    logic [11:0] alu;
    logic [2:0]  md;
    logic        mem_we;
    logic        rfm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] rkd;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[NV];
  logic [70:0] sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          en_cnt   = 0;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_we;
  logic        last_isload;

  function automatic vec_t mk(input logic [11:0] alu, input logic [2:0] md,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] exp);
    vec_t v;
    v.alu = alu; v.md = md; v.mem_we = 1'b0; v.rfm = 1'b0; v.gr_we = 1'b1;
    v.dest = 5'd3; v.s1 = s1; v.s2 = s2; v.rkd = 32'd0; v.pc = 32'd0;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [150:0] pack(input vec_t v);
    return {v.alu, v.md, v.mem_we, v.rfm, v.gr_we, v.dest,
            v.s1, v.s2, v.rkd, v.pc};
  endfunction

  function automatic logic [70:0] expect_of(input vec_t v);
    return {v.rfm, v.gr_we, v.dest, v.exp, v.pc};
  endfunction

  task automatic chk(input string name, input logic [70:0] act,
                     input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Sampled at the falling edge, with inputs stable for the next rising edge.
  task automatic monitor();
    logic [70:0] e;
    if (data_sram_en) begin
      en_cnt++;
      last_addr   = data_sram_addr;
      last_we     = data_sram_we;
      last_wdata  = data_sram_wdata;
      last_isload = es_to_ds_bus[37];
    end
    if (es_to_ms_valid && ms_allowin) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_transfer actual=%h expected=none", es_to_ms_bus);
      end else begin
        e = sb.pop_front();
        chk("es_to_ms_bus", es_to_ms_bus, e);
        chk("fwd_result", 71'(es_to_ds_bus[31:0]), 71'(e[63:32]));
        chk("fwd_valid", 71'(es_to_ds_bus[38]), 71'(e[69] && (e[68:64] != 5'd0)));
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    at_neg();
    to_pos();
  endtask

  task automatic issue(input vec_t v);
    logic acc;
    logic done;
    done = 1'b0;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = pack(v);
    for (int n = 0; n < 200 && !done; n++) begin
      at_neg();
      acc = es_allowin;
      to_pos();
      if (acc) begin
        sb.push_back(expect_of(v));
        done = 1'b1;
      end
    end
    ds_to_es_valid = 1'b0;
    if (!done) chk("issue_timeout", 71'(0), 71'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() > 0; n++) cyc();
    chk("drain_left", 71'(sb.size()), 71'(0));
  endtask

  // Counts EX cycles from acceptance (cycle 1) to the first es_to_ms_valid.
  // Optionally offers a younger op, which is accepted in the transfer cycle.
  task automatic measure(input bit push_y, input vec_t y, output int lat,
                         output logic allow1);
    bit found;
    found  = 1'b0;
    lat    = -1;
    allow1 = 1'bx;
    if (push_y) begin
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = pack(y);
    end
    for (int k = 1; k <= 60 && !found; k++) begin
      at_neg();
      if (k == 1) allow1 = es_allowin;
      if (es_to_ms_valid) begin
        lat   = k;
        found = 1'b1;
        if (push_y && es_allowin) sb.push_back(expect_of(y));
      end
      to_pos();
    end
    ds_to_es_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t y;
    int   lat;
    logic allow1;

    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;

    vecs[0]  = mk(A_ADD,  3'b000, 32'd5,         32'hFFFF_FFFD, 32'd2);
    vecs[1]  = mk(A_SUB,  3'b000, 32'd3,         32'd5,         32'hFFFF_FFFE);
    vecs[2]  = mk(A_SLT,  3'b000, 32'hFFFF_FFFF, 32'd1,         32'd1);
    vecs[3]  = mk(A_SLTU, 3'b000, 32'hFFFF_FFFF, 32'd1,         32'd0);
    vecs[4]  = mk(A_SLTU, 3'b000, 32'd1,         32'hFFFF_FFFF, 32'd1);
    vecs[5]  = mk(A_AND,  3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    vecs[6]  = mk(A_NOR,  3'b000, 32'h0F0F_0000, 32'h0000_FFFF, 32'hF0F0_0000);
    vecs[7]  = mk(A_OR,   3'b000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    vecs[8]  = mk(A_XOR,  3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    vecs[9]  = mk(A_SLL,  3'b000, 32'd1,         32'h0000_0021, 32'd2);
    vecs[10] = mk(A_SRL,  3'b000, 32'h8000_0000, 32'd4,         32'h0800_0000);
    vecs[11] = mk(A_SRA,  3'b000, 32'h8000_0000, 32'd4,         32'hF800_0000);
    vecs[12] = mk(A_LUI,  3'b000, 32'h1111_1111, 32'hABCD_0000, 32'hABCD_0000);
    vecs[13] = mk(12'h0,  3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    vecs[14] = mk(A_ADD,  3'b001, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    vecs[15] = mk(A_ADD,  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    vecs[16] = mk(A_ADD,  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    vecs[17] = mk(A_ADD,  3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    vecs[18] = mk(A_ADD,  3'b101, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    vecs[19] = mk(A_ADD,  3'b110, 32'd12345,     32'd0,         32'hFFFF_FFFF);
    vecs[20] = mk(A_ADD,  3'b111, 32'd9,         32'd0,         32'd9);
    vecs[21] = mk(A_ADD,  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    vecs[22] = mk(A_ADD,  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    vecs[23] = mk(A_ADD,  3'b110, 32'd100,       32'd7,         32'd14);
    vecs[24] = mk(A_ADD,  3'b111, 32'd100,       32'd7,         32'd2);
    vecs[25] = mk(A_ADD,  3'b101, 32'd7,         32'hFFFF_FFFE, 32'd1);
    vecs[26] = mk(A_ADD,  3'b101, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    at_neg();
    chk("rst_allowin",    71'(es_allowin),       71'(1));
    chk("rst_to_ms_valid", 71'(es_to_ms_valid),  71'(0));
    chk("rst_fwd_valid",  71'(es_to_ds_bus[38]), 71'(0));
    chk("rst_sram_en",    71'(data_sram_en),     71'(0));
    chk("rst_sram_we",    71'(data_sram_we),     71'(0));
    to_pos();

    // Table-driven ALU / multiply / divide vectors
    for (int i = 0; i < NV; i++) begin
      if (i != 0) vecs[i].dest = 5'((i % 29) + 3);
      vecs[i].pc = 32'h1000 + 32'(4 * i);
      issue(vecs[i]);
      drain();
    end

    // Load: one request, address = ALU sum, no write enables
    v = mk(A_ADD, 3'b000, 32'h1000, 32'd4, 32'h1004);
    v.rfm = 1'b1; v.dest = 5'd5; v.pc = 32'h2000;
    en_cnt = 0;
    issue(v);
    drain();
    cyc();
    cyc();
    chk("load_en_count", 71'(en_cnt),      71'(1));
    chk("load_addr",     71'(last_addr),   71'(32'h1004));
    chk("load_we",       71'(last_we),     71'(0));
    chk("load_is_load",  71'(last_isload), 71'(1));

    // Store held by MEM for three cycles
    v = mk(A_ADD, 3'b000, 32'h2000, 32'd8, 32'h2008);
    v.mem_we = 1'b1; v.gr_we = 1'b0; v.dest = 5'd0; v.rkd = 32'hDEAD_BEEF;
    v.pc = 32'h2004;
    ms_allowin = 1'b0;
    issue(v);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("store_stall_en", 71'(data_sram_en), 71'(0));
      chk("store_stall_we", 71'(data_sram_we), 71'(0));
      to_pos();
    end
    ms_allowin = 1'b1;
    at_neg();
    chk("store_en",    71'(data_sram_en),    71'(1));
    chk("store_we",    71'(data_sram_we),    71'(4'hF));
    chk("store_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
    chk("store_addr",  71'(data_sram_addr),  71'(32'h2008));
    to_pos();
    at_neg();
    chk("store_en_after", 71'(data_sram_en), 71'(0));
    to_pos();

    // div.w -7/2 with a younger add waiting behind it
    v = mk(A_ADD, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    v.dest = 5'd7; v.pc = 32'h3000;
    y = mk(A_ADD, 3'b000, 32'd1, 32'd2, 32'd3);
    y.dest = 5'd8; y.pc = 32'h3004;
    issue(v);
    measure(1'b1, y, lat, allow1);
    chk("div_latency",     71'(lat),    71'(34));
    chk("div_stall_allow", 71'(allow1), 71'(0));
    drain();

    // mod.w -7/2 reaching DONE while MEM refuses: result held, no request
    v = mk(A_ADD, 3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    v.dest = 5'd9; v.pc = 32'h3008;
    issue(v);
    ms_allowin = 1'b0;
    repeat (36) cyc();
    at_neg();
    chk("done_hold_valid",  71'(es_to_ms_valid),     71'(1));
    chk("done_hold_result", 71'(es_to_ds_bus[31:0]), 71'(32'hFFFF_FFFF));
    chk("done_hold_sram",   71'(data_sram_en),       71'(0));
    to_pos();
    ms_allowin = 1'b1;
    drain();

    // Reset in the middle of a divide, then a fresh divide
    v = mk(A_ADD, 3'b110, 32'd100, 32'd7, 32'd14);
    v.dest = 5'd10; v.pc = 32'h4000;
    issue(v);
    repeat (8) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    at_neg();
    chk("mid_rst_to_ms_valid", 71'(es_to_ms_valid),    71'(0));
    chk("mid_rst_allowin",     71'(es_allowin),        71'(1));
    chk("mid_rst_fwd_valid",   71'(es_to_ds_bus[38]),  71'(0));
    to_pos();
    v = mk(A_ADD, 3'b100, 32'd100, 32'd7, 32'd14);
    v.dest = 5'd11; v.pc = 32'h4004;
    issue(v);
    measure(1'b0, y, lat, allow1);
    chk("post_rst_latency", 71'(lat), 71'(34));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
